// File: rtl/spi_slave_core.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spi_slave_core                                                |
// | Purpose  : SPI slave, all four modes, selectable bit order; sclk/cs/mosi0|
// |            oversampled on pclk. Define SPI_SLAVE_OVERRUN_EN for a sticky |
// |            overrun flag with overrun/overrun_clr ports.                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module spi_slave_core #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  msb_first,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi0,
    output logic                  miso0,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready
`ifdef SPI_SLAVE_OVERRUN_EN
   ,output logic                  overrun,
    input  logic                  overrun_clr
`endif
);

    localparam int                 c_cnt_w     = $clog2(DATA_WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_full      = c_cnt_w'(DATA_WIDTH);
    localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);
    localparam logic [0:0]         c_st_idle   = 1'b0;
    localparam logic [0:0]         c_st_active = 1'b1;

    // The tx shift register always emits from its MSB; LSB-first words are
    // bit-reversed on load so a single left shift serves both orders.
    function automatic logic [DATA_WIDTH-1:0] f_order(input logic [DATA_WIDTH-1:0] d,
                                                      input logic                  msbf);
        logic [DATA_WIDTH-1:0] v;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            v[i] = msbf ? d[i] : d[DATA_WIDTH-1-i];
        end
        return v;
    endfunction

    logic [2:0]            r_sync [SYNC_STAGES];
    logic                  r_sclk_d;
    logic                  r_cs_d;
    logic [0:0]            r_state;
    logic                  r_cpol;
    logic                  r_cpha;
    logic                  r_msb_first;
    logic [c_cnt_w-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_tx_sr;
    logic [DATA_WIDTH-1:0] r_rx_sr;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic                  r_tx_ready;
    logic                  r_miso0;
    logic                  r_miso_oe;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic                  r_overrun;
`endif

    logic                  w_sclk_s;
    logic                  w_cs_s;
    logic                  w_mosi_s;
    logic                  w_sclk_rise;
    logic                  w_sclk_fall;
    logic                  w_lead;
    logic                  w_trail;
    logic                  w_sample;
    logic                  w_shift;
    logic                  w_cs_fall;
    logic                  w_cs_rise;
    logic [DATA_WIDTH-1:0] w_load_word;
    logic [DATA_WIDTH-1:0] w_start_sr;
    logic [DATA_WIDTH-1:0] w_reload_sr;

    assign w_sclk_s    = r_sync[SYNC_STAGES-1][2];
    assign w_cs_s      = r_sync[SYNC_STAGES-1][1];
    assign w_mosi_s    = r_sync[SYNC_STAGES-1][0];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_lead      = r_cpol ? w_sclk_fall : w_sclk_rise;
    assign w_trail     = r_cpol ? w_sclk_rise : w_sclk_fall;
    assign w_sample    = r_cpha ? w_trail : w_lead;
    assign w_shift     = r_cpha ? w_lead : w_trail;
    assign w_cs_fall   = ~w_cs_s & r_cs_d;
    assign w_cs_rise   = w_cs_s & ~r_cs_d;
    assign w_load_word = tx_valid ? tx_data : '0;
    assign w_start_sr  = f_order(w_load_word, msb_first);
    assign w_reload_sr = f_order(w_load_word, r_msb_first);

    always_ff @(posedge pclk) begin
        if (areset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b0;
            r_state     <= c_st_idle;
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_msb_first <= 1'b0;
            r_bit_cnt   <= '0;
            r_tx_sr     <= '0;
            r_rx_sr     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_tx_ready  <= 1'b0;
            r_miso0     <= 1'b0;
            r_miso_oe   <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
            r_overrun   <= 1'b0;
`endif
        end else begin
            r_sync[0] <= {sclk, cs, mosi0};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_sclk_d   <= w_sclk_s;
            r_cs_d     <= w_cs_s;
            r_tx_ready <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
            if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
`endif
            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            case (r_state)
                c_st_idle: begin
                    if (w_cs_fall) begin
                        r_state     <= c_st_active;
                        r_cpol      <= cpol;
                        r_cpha      <= cpha;
                        r_msb_first <= msb_first;
                        r_tx_sr     <= w_start_sr;
                        r_miso0     <= w_start_sr[DATA_WIDTH-1];
                        r_miso_oe   <= 1'b1;
                        r_tx_ready  <= tx_valid;
                        r_bit_cnt   <= '0;
                    end
                end
                c_st_active: begin
                    if (w_cs_rise) begin
                        r_state   <= c_st_idle;
                        r_miso0   <= 1'b0;
                        r_miso_oe <= 1'b0;
                        r_bit_cnt <= '0;
                    end else if (r_bit_cnt == c_full) begin
                        r_rx_data  <= r_rx_sr;
                        r_rx_valid <= 1'b1;
`ifdef SPI_SLAVE_OVERRUN_EN
                        if (r_rx_valid && !rx_ready) begin
                            r_overrun <= 1'b1;
                        end
`endif
                        r_bit_cnt  <= '0;
                        r_tx_sr    <= w_reload_sr;
                        r_miso0    <= w_reload_sr[DATA_WIDTH-1];
                        r_tx_ready <= tx_valid;
                    end else begin
                        if (w_sample) begin
                            r_rx_sr   <= r_msb_first ? {r_rx_sr[DATA_WIDTH-2:0], w_mosi_s}
                                                     : {w_mosi_s, r_rx_sr[DATA_WIDTH-1:1]};
                            r_bit_cnt <= r_bit_cnt + c_one;
                        end
                        // A shift edge seen with an empty counter precedes the
                        // word's first sample: the first bit is already out.
                        if (w_shift && (r_bit_cnt != '0)) begin
                            r_tx_sr <= {r_tx_sr[DATA_WIDTH-2:0], 1'b0};
                            r_miso0 <= r_tx_sr[DATA_WIDTH-2];
                        end
                    end
                end
                default: begin
                    r_state   <= c_st_idle;
                    r_miso0   <= 1'b0;
                    r_miso_oe <= 1'b0;
                end
            endcase
        end
    end

    assign miso0    = r_miso0;
    assign miso_oe  = r_miso_oe;
    assign tx_ready = r_tx_ready;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
`ifdef SPI_SLAVE_OVERRUN_EN
    assign overrun  = r_overrun;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_core.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_spi_slave_core                                             |
// | Purpose  : word-level SPI master model driving spi_slave_core            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_spi_slave_core;
    localparam int HP     = 8;
    localparam int SETTLE = 6;

    logic       pclk = 1'b0;
    logic       areset, cpol, cpha, msb_first, sclk, cs, mosi0, rx_ready;
    logic       miso0, miso_oe, tx_ready, rx_valid, tx_valid;
    logic [7:0] rx_data, tx_data;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic       overrun, overrun_clr;
`endif

    always #5 pclk = ~pclk;

    int         total = 0, bad = 0, cyc = 0, last_change = 0, rx_events = 0;
    logic       frame_live = 1'b0;
    logic [7:0] exp_rx[$];
    logic [7:0] tq[4];
    int         tq_n = 0, txr_total = 0, txr_base = 0;
    logic [7:0] mw[4], mrx[4];
    logic [7:0] last_rx = 8'h00;
    logic       p_valid = 1'b0, p_ready = 1'b0;
    logic [7:0] p_data = 8'h00;

    assign tx_valid = (txr_total - txr_base) < tq_n;
    assign tx_data  = tx_valid ? tq[(txr_total - txr_base) & 3] : 8'h00;

    spi_slave_core #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .pclk(pclk), .areset(areset), .cpol(cpol), .cpha(cpha), .msb_first(msb_first),
        .sclk(sclk), .cs(cs), .mosi0(mosi0), .miso0(miso0), .miso_oe(miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
`ifdef SPI_SLAVE_OVERRUN_EN
       ,.overrun(overrun), .overrun_clr(overrun_clr)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic mark();
        last_change = cyc;
    endtask

    function automatic logic bitof(input logic [7:0] w, input int b, input logic msbf);
        return msbf ? w[7-b] : w[b];
    endfunction

    function automatic logic [7:0] exp_tx(input int w);
        return (w < tq_n) ? tq[w] : 8'h00;
    endfunction

    // Compare process: output enable / idle line every settled cycle, and each
    // delivered word against the queue of words the master finished sending.
    always @(negedge pclk) begin
        cyc++;
        if (tx_ready) txr_total++;
        if (!areset && (cyc - last_change) > SETTLE) begin
            chk("miso_oe", {31'b0, miso_oe}, {31'b0, frame_live});
            if (!frame_live) chk("miso0_idle", {31'b0, miso0}, 32'h0);
        end
        if (rx_valid && p_valid && p_ready && rx_data == p_data) begin
            chk("rx_valid_clear", {31'b0, rx_valid}, 32'h0);
        end else if (rx_valid && (!p_valid || p_ready || rx_data != p_data)) begin
            rx_events++;
            if (exp_rx.size() == 0) chk("rx_unexpected", {31'b0, rx_valid}, 32'h0);
            else chk("rx_data", {24'b0, rx_data}, {24'b0, exp_rx.pop_front()});
            last_rx = rx_data;
        end
        p_valid = rx_valid;
        p_ready = rx_ready;
        p_data  = rx_data;
    end

    task automatic xfer(input logic cp, input logic ch, input logic mf, input int nw,
                        input int abort_bits);
        int nbits, nfull, w, b, expn;
        cpol = cp; cpha = ch; msb_first = mf; sclk = cp; mosi0 = 1'b0;
        txr_base = txr_total;
        tick(6);
        nbits = (abort_bits > 0) ? abort_bits : nw * 8;
        nfull = (abort_bits > 0) ? 0 : nw;
        for (int k = 0; k < 4; k++) mrx[k] = 8'h00;
        if (!ch) mosi0 = bitof(mw[0], 0, mf);
        cs = 1'b0; frame_live = 1'b1; mark();
        tick(HP);
        for (int i = 0; i < nbits; i++) begin
            w = i / 8; b = i % 8;
            sclk = ~cp;
            if (!ch) begin
                mrx[w][mf ? 7-b : b] = miso0;
                if (b == 7) exp_rx.push_back(mw[w]);
            end else begin
                mosi0 = bitof(mw[w], b, mf);
            end
            tick(HP);
            sclk = cp;
            if (ch) begin
                mrx[w][mf ? 7-b : b] = miso0;
                if (b == 7) exp_rx.push_back(mw[w]);
            end else if (i + 1 < nbits) begin
                mosi0 = bitof(mw[(i+1)/8], (i+1)%8, mf);
            end
            tick(HP);
        end
        cs = 1'b1; frame_live = 1'b0; mark();
        tick(2*HP);
        for (int k = 0; k < nfull; k++) chk("master_rx", {24'b0, mrx[k]}, {24'b0, exp_tx(k)});
        expn = (nfull + 1 < tq_n) ? nfull + 1 : tq_n;
        chk("tx_ready_count", txr_total - txr_base, expn);
        chk("rx_pending", exp_rx.size(), 0);
    endtask

    initial begin
        int ev0;
        logic [3:0] m;
        areset = 1'b1; cs = 1'b1; sclk = 1'b0; mosi0 = 1'b0; cpol = 1'b0; cpha = 1'b0;
        msb_first = 1'b1; rx_ready = 1'b1;
`ifdef SPI_SLAVE_OVERRUN_EN
        overrun_clr = 1'b0;
`endif
        tick(5);
        areset = 1'b0; mark();
        tick(2);
        chk("reset_rx_valid", {31'b0, rx_valid}, 32'h0);
        chk("reset_rx_data", {24'b0, rx_data}, 32'h0);
        chk("reset_tx_ready", {31'b0, tx_ready}, 32'h0);
        chk("reset_miso_oe", {31'b0, miso_oe}, 32'h0);
        chk("reset_miso0", {31'b0, miso0}, 32'h0);
`ifdef SPI_SLAVE_OVERRUN_EN
        chk("reset_overrun", {31'b0, overrun}, 32'h0);
`endif

        // Mode 0, MSB first, 0xA5 in / 0x3C out
        mw[0] = 8'hA5; tq[0] = 8'h3C; tq_n = 1; last_rx = 8'h00;
        xfer(1'b0, 1'b0, 1'b1, 1, 0);
        chk("t1_rx", {24'b0, last_rx}, 32'hA5);
        chk("t1_master", {24'b0, mrx[0]}, 32'h3C);
        chk("t1_tx_ready", txr_total - txr_base, 1);

        // Every mode, LSB first, 0x01
        for (int md = 0; md < 4; md++) begin
            m = md[3:0];
            mw[0] = 8'h01; tq[0] = 8'($urandom); tq_n = 1; last_rx = 8'hFF;
            xfer(m[1], m[0], 1'b0, 1, 0);
            chk("t2_rx_mode", {24'b0, last_rx}, 32'h01);
        end

        // Back-to-back words in one frame
        mw[0] = 8'h11; mw[1] = 8'h22; tq[0] = 8'h96; tq[1] = 8'h69; tq_n = 2;
        ev0 = rx_events;
        xfer(1'b0, 1'b0, 1'b1, 2, 0);
        chk("t3_events", rx_events - ev0, 2);
        chk("t3_last", {24'b0, last_rx}, 32'h22);

        // Abort after 5 bits
        mw[0] = 8'hB7; tq[0] = 8'h5E; tq_n = 1; ev0 = rx_events;
        xfer(1'b1, 1'b1, 1'b1, 1, 5);
        chk("t4_events", rx_events - ev0, 0);
        chk("t4_miso_oe", {31'b0, miso_oe}, 32'h0);
        chk("t4_rx_valid", {31'b0, rx_valid}, 32'h0);

        // Nothing to send
        mw[0] = 8'h5A; tq_n = 0;
        xfer(1'b0, 1'b1, 1'b1, 1, 0);
        chk("t5_master", {24'b0, mrx[0]}, 32'h00);

        // Consumer stalled across two words
        rx_ready = 1'b0; mw[0] = 8'h11; mw[1] = 8'h22; tq_n = 0;
        xfer(1'b0, 1'b0, 1'b1, 2, 0);
        chk("t6_rx_valid", {31'b0, rx_valid}, 32'h1);
        chk("t6_rx_data", {24'b0, rx_data}, 32'h22);
`ifdef SPI_SLAVE_OVERRUN_EN
        chk("t6_overrun_set", {31'b0, overrun}, 32'h1);
        tick(10);
        chk("t6_overrun_hold", {31'b0, overrun}, 32'h1);
        overrun_clr = 1'b1; tick(1); overrun_clr = 1'b0; tick(1);
        chk("t6_overrun_clr", {31'b0, overrun}, 32'h0);
`endif
        rx_ready = 1'b1; tick(2);
        chk("t6_rx_accept", {31'b0, rx_valid}, 32'h0);

        // Reset in the middle of a frame, cs stays low afterwards
        tq_n = 0; cpol = 1'b0; cpha = 1'b0; msb_first = 1'b1; sclk = 1'b0; mosi0 = 1'b1;
        tick(6);
        cs = 1'b0; frame_live = 1'b1; mark(); tick(HP);
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b1; tick(HP); sclk = 1'b0; tick(HP);
        end
        areset = 1'b1; frame_live = 1'b0; mark(); tick(2);
        areset = 1'b0; mark(); tick(1);
        chk("t7_rx_data", {24'b0, rx_data}, 32'h0);
        chk("t7_rx_valid", {31'b0, rx_valid}, 32'h0);
        ev0 = rx_events;
        for (int i = 0; i < 10; i++) begin
            sclk = 1'b1; tick(HP); sclk = 1'b0; tick(HP);
        end
        chk("t7_events", rx_events - ev0, 0);
        cs = 1'b1; mark(); tick(2*HP);
        mw[0] = 8'hC3; tq[0] = 8'h81; tq_n = 1;
        xfer(1'b0, 1'b0, 1'b1, 1, 0);
        chk("t7_recover", {24'b0, last_rx}, 32'hC3);

        // Randomized frames
        for (int f = 0; f < 20; f++) begin
            m = 4'($urandom);
            tq_n = $urandom_range(0, 3);
            for (int k = 0; k < 4; k++) begin
                mw[k] = 8'($urandom);
                tq[k] = 8'($urandom);
            end
            xfer(m[0], m[1], m[2], $urandom_range(1, 3), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
